// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache line constants and types for the fill and eviction paths
package cache_pkg;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int CNT_W          = $clog2(WORDS_PER_LINE);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } deser_state_t;
endpackage

// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - fill-path handshake between memory side, deserializer and cache array
interface deserializer_if;
  import cache_pkg::*;

  logic  start;
  word_t word_in;
  logic  word_valid;
  logic  word_ready;
  line_t line_out;
  logic  line_valid;
  logic  line_ack;
  logic  busy;
  logic  stray;

  modport master (
    output start, word_in, word_valid, line_ack,
    input  word_ready, line_out, line_valid, busy, stray
  );

  modport slave (
    input  start, word_in, word_valid, line_ack,
    output word_ready, line_out, line_valid, busy, stray
  );
endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - collects eight memory words into one 256-bit cache line
module deserializer
  import cache_pkg::*;
(
  input logic           clk,
  input logic           rst,
  deserializer_if.slave bus
);

  deser_state_t     state;
  deser_state_t     state_nxt;
  logic [CNT_W-1:0] cnt;
  line_t            buffer;
  logic             stray_q;
  logic             restart;
  logic             accept;
  logic             ready;
  logic             valid;
  logic             busy;

  // State register; reset drops any partially collected line.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and state-derived handshake outputs.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    ready     = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = FILL;
          restart   = 1'b1;
        end
      end
      FILL: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (bus.word_valid && cnt == CNT_W'(WORDS_PER_LINE - 1)) state_nxt = DONE;
      end
      DONE: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (bus.line_ack) begin
          // Ack with start chains straight into the next fill, no IDLE gap.
          state_nxt = bus.start ? FILL : IDLE;
          restart   = bus.start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = ready && bus.word_valid;

  // Word counter and line buffer; the counter wraps to 0 on the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      buffer <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (accept) begin
      buffer[cnt] <= bus.word_in;
      cnt         <= cnt + CNT_W'(1);
    end
  end

  // Diagnostic: a word offered while not ready is dropped and flagged next cycle.
  always_ff @(posedge clk) begin
    if (rst) stray_q <= 1'b0;
    else     stray_q <= bus.word_valid && !ready;
  end

  assign bus.word_ready = ready;
  assign bus.line_valid = valid;
  assign bus.busy       = busy;
  assign bus.stray      = stray_q;
  assign bus.line_out   = buffer;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - self-checking bench for the cache-fill deserializer
module tb_deserializer;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deserializer_if bus();
  deserializer dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference: mode 0 = waiting, 1 = collecting, 2 = holding a finished line.
  int          m_mode;
  int          m_count;
  logic [31:0] m_words[8];
  logic        m_stray;

  typedef struct {
    logic        r, st, wv, ack;
    logic [31:0] w;
    logic        e_ready, e_valid, e_busy, e_stray;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic st, logic wv, logic [31:0] w, logic ack,
                              logic er, logic ev, logic eb, logic es);
    vec_t v;
    v.r = r; v.st = st; v.wv = wv; v.w = w; v.ack = ack;
    v.e_ready = er; v.e_valid = ev; v.e_busy = eb; v.e_stray = es;
    return v;
  endfunction

  function automatic logic [255:0] seq_line(logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [255:0] model_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = m_words[i];
    return l;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkl(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(logic r, logic st, logic wv, logic [31:0] w, logic ack);
    m_stray = wv && (m_mode != 1);
    if (r) begin
      m_mode  = 0;
      m_count = 0;
      m_stray = 1'b0;
      for (int i = 0; i < 8; i++) m_words[i] = '0;
    end else if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_count = 0; end
    end else if (m_mode == 1) begin
      if (wv) begin
        m_words[m_count] = w;
        m_count++;
        if (m_count == 8) begin m_mode = 2; m_count = 0; end
      end
    end else begin
      if (ack) begin m_mode = st ? 1 : 0; m_count = 0; end
    end
  endtask

  task automatic check_model();
    chk1("model word_ready", bus.word_ready, m_mode == 1);
    chk1("model line_valid", bus.line_valid, m_mode == 2);
    chk1("model busy", bus.busy, m_mode != 0);
    chk1("model stray", bus.stray, m_stray);
    chkl("model line_out", bus.line_out, model_line());
  endtask

  task automatic step(logic r, logic st, logic wv, logic [31:0] w, logic ack);
    rst = r; bus.start = st; bus.word_valid = wv; bus.word_in = w; bus.line_ack = ack;
    @(posedge clk);
    model_edge(r, st, wv, w, ack);
    @(negedge clk);
    check_model();
  endtask

  task automatic fill(logic [31:0] base);
    for (int i = 0; i < 8; i++) step(0, 0, 1, base + 32'(i), 0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 0; bus.word_valid = 0; bus.word_in = '0; bus.line_ack = 0;
    m_mode = 0; m_count = 0; m_stray = 0;
    for (int i = 0; i < 8; i++) m_words[i] = '0;

    // Basic fill, latency, then DONE held with stray words offered.
    tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 1, 32'h1000_0000 + 32'(i), 0, i != 7, i == 7, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 1, 0, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].st, tbl[i].wv, tbl[i].w, tbl[i].ack);
      chk1($sformatf("tbl[%0d] word_ready", i), bus.word_ready, tbl[i].e_ready);
      chk1($sformatf("tbl[%0d] line_valid", i), bus.line_valid, tbl[i].e_valid);
      chk1($sformatf("tbl[%0d] busy", i), bus.busy, tbl[i].e_busy);
      chk1($sformatf("tbl[%0d] stray", i), bus.stray, tbl[i].e_stray);
      if (i == 9 || i == 14)
        chkl($sformatf("tbl[%0d] line_out", i), bus.line_out, seq_line(32'h1000_0000));
    end

    // Stalled fill: word_valid low every other cycle.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 32'hFFFF_FFFF, 0);
      chk1("stall no early valid", bus.line_valid, 1'b0);
      step(0, 0, 1, 32'h1000_0000 + 32'(i), 0);
    end
    chk1("stall line_valid", bus.line_valid, 1'b1);
    chkl("stall line_out", bus.line_out, seq_line(32'h1000_0000));

    // Back-to-back: ack with start in the same DONE cycle.
    step(0, 1, 0, 0, 1);
    chk1("b2b busy", bus.busy, 1'b1);
    chk1("b2b word_ready", bus.word_ready, 1'b1);
    chkl("b2b old line held", bus.line_out, seq_line(32'h1000_0000));
    fill(32'h0000_00A0);
    chk1("b2b line_valid", bus.line_valid, 1'b1);
    chkl("b2b line_out", bus.line_out, seq_line(32'h0000_00A0));

    // Reset after three accepted words.
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h7700_0000 + 32'(i), 0);
    step(1, 0, 0, 0, 0);
    chk1("rst line_valid", bus.line_valid, 1'b0);
    chk1("rst busy", bus.busy, 1'b0);
    chkl("rst line_out", bus.line_out, '0);
    step(0, 1, 0, 0, 0);
    fill(32'h0000_0005);
    chkl("after rst line_out", bus.line_out, seq_line(32'h0000_0005));

    // Ignored inputs: ack in IDLE/FILL, start during FILL.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk1("ack idle busy", bus.busy, 1'b0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, i[0], 1, 32'h0000_0300 + 32'(i), i[1]);
      if (i < 7) chk1("ignored in fill", bus.line_valid, 1'b0);
    end
    chkl("ignored line_out", bus.line_out, seq_line(32'h0000_0300));

    // Randomized traffic against the reference.
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
           $urandom, $urandom_range(2) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Cache-fill stage: collects eight 32-bit words returned by the memory interface and assembles them into one 256-bit cache line for the cache data array.
- Sits on the read (fill) path, mirroring the write-back serializer on the eviction path.
- Word ordering matches the serializer: the first word transferred is line word 0, at line bits [31:0].

Parameters:
- WORD_W, 32, width of one memory-side word.
- WORDS, 8, words per cache line; LINE_W = WORD_W*WORDS = 256.

Ports:
- clk, input, 1, system clock; all logic is on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to begin collecting a new line.
- word_in, input, WORD_W, word from the memory side.
- word_valid, input, 1, word_in is valid this cycle.
- word_ready, output, 1, block accepts word_in this cycle.
- line_out, output, LINE_W, assembled line; word i is at bits [i*32+31 : i*32].
- line_valid, output, 1, line_out is complete and stable.
- line_ack, input, 1, consumer has taken line_out.
- busy, output, 1, high in FILL or DONE.
- stray, output, 1, one-cycle pulse when word_valid is high while word_ready is low.

Behaviour:
- State machine: IDLE, FILL, DONE. Word counter cnt has width $clog2(WORDS) (3 bits). Line buffer is WORDS registers of WORD_W.
- Reset, on any cycle including mid-fill:
  - state=IDLE, cnt=0, line buffer all zero.
  - line_valid=0, word_ready=0, busy=0, stray=0.
  - Any partially collected line is discarded.
- IDLE:
  - word_ready=0, busy=0.
  - start=1 -> FILL next cycle with cnt=0.
- FILL:
  - word_ready=1 combinationally from state (no dependence on word_valid).
  - Accept condition: word_valid && word_ready. On accept, buffer[cnt] <= word_in and cnt <= cnt+1.
  - Accepting with cnt==WORDS-1 -> DONE next cycle, cnt wraps to 0.
  - word_valid=0 cycles are stalls: no state change and no limit on length.
- DONE:
  - line_valid=1, word_ready=0; line_out is held stable until acknowledged.
  - line_ack=1 and start=0 -> IDLE next cycle.
  - line_ack=1 and start=1 -> FILL next cycle with cnt=0 (back-to-back fills). The previous line_out is still held that cycle; buffer words are overwritten as new words arrive.
- Ignored inputs:
  - start in FILL, and start in DONE without line_ack, has no effect.
  - line_ack outside DONE has no effect.
- Latency: the 8th word is accepted on cycle N; line_valid=1 on cycle N+1. Minimum fill is start at cycle 0 to line_valid at cycle 9, with no stalls.
- line_out: driven directly from the buffer registers, so it shows partial contents during FILL. Consumers must qualify it with line_valid.
- stray:
  - Registered, asserted the cycle after word_valid && !word_ready; the word is dropped.
  - Only diagnostic; it does not change state.
  - Reset clears it.

Decomposition:
- Shared package cache_pkg:
  - constants WORD_W=32, WORDS_PER_LINE=8, LINE_W=256;
  - typedef word_t (logic [31:0]);
  - typedef line_t (logic [7:0][31:0]);
  - enum deser_state_t {IDLE, FILL, DONE}.
- The same package constants are used by the serializer.
- No sub-module; the counter and buffer stay inline (~150 lines).

Test Plan:
- Reset then start, then words 0x1000_0000..0x1000_0007 on consecutive cycles -> line_valid high exactly 9 cycles after start; line_out = {0x10000007,...,0x10000000}; busy high throughout.
- Same fill with word_valid low on every other cycle -> word count unchanged by stalls; line_valid 1 cycle after the 8th accept; same line_out.
- Hold line_ack=0 for 5 cycles in DONE while word_valid=1 with word 0xDEADBEEF -> line_out unchanged, word_ready=0, stray pulses each cycle; line_ack=1 -> IDLE.
- line_ack=1 and start=1 in the same DONE cycle, then words 0xA0..0xA7 -> no IDLE cycle, second line = {0xA7,...,0xA0}.
- Assert rst after 3 words accepted -> next cycle state IDLE, line_valid=0, line_out=0; a new fill of 0x5..0xC completes correctly.
- start pulses during FILL, and line_ack during IDLE/FILL -> no effect on cnt or state.
